mpc_vec_addsub_sat: RTL

//  Parametrised saturating vector add/subtract engine for the ADMM QP solver: y[i] = sat(a[i] -/+ b[i]), i=0..N-1.

---
 rtl/mpc_vec_addsub_sat.sv | 81 ++++++++
 1 files changed

// File: rtl/mpc_vec_addsub_sat.sv
// mpc_vec_addsub_sat: element-serial saturating vector add/subtract under an ap_start/ap_done handshake
module mpc_vec_addsub_sat #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic                              ap_start,
    output logic                              ap_ready,
    output logic                              ap_idle,
    output logic                              ap_done,
    input  logic                              mode,
    input  logic [N*W-1:0]                    a_vec,
    input  logic [N*W-1:0]                    b_vec,
    output logic [N*W-1:0]                    y_vec,
    output logic                              sat_flag,
    output logic [$clog2(N+1)-1:0]            sat_cnt
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [N-1:0][W-1:0] a_r, b_r, y_r;
    logic mode_r;
    logic [IDXW-1:0] idx;
    logic [W-1:0] a_e, b_e, y_e;
    logic [W:0] r;
    logic sat, last;
    always_comb begin
        a_e = '0;
        b_e = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                a_e = a_r[i];
                b_e = b_r[i];
            end
        end
    end
    // one guard bit is enough: overflow shows as disagreement between the top two bits
    assign r = mode_r ? {a_e[W-1], a_e} + {b_e[W-1], b_e} : {a_e[W-1], a_e} - {b_e[W-1], b_e};
    assign sat = r[W] ^ r[W-1];
    assign y_e = sat ? {r[W], {(W-1){~r[W]}}} : r[W-1:0];
    assign last = idx == IDXW'(N - 1);
    always_comb begin
        nxt = state == IDLE ? (ap_start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    assign ap_idle = state == IDLE;
    assign ap_ready = ap_idle && ap_start;
    assign ap_done = state == DONE;
    assign y_vec = y_r;
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            idx <= '0;
            y_r <= '0;
            sat_flag <= 1'b0;
            sat_cnt <= '0;
        end else begin
            state <= nxt;
            if (ap_ready) begin
                a_r <= a_vec;
                b_r <= b_vec;
                mode_r <= mode;
                idx <= '0;
                sat_flag <= 1'b0;
                sat_cnt <= '0;
            end
            if (state == RUN) begin
                idx <= idx + 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (idx == IDXW'(i)) y_r[i] <= y_e;
                end
                if (sat) begin
                    sat_flag <= 1'b1;
                    sat_cnt <= sat_cnt + CNTW'(1);
                end
            end
        end
    end
endmodule
